// File: rtl/cond_branch_seq.sv
// Conditional-branch instruction sequencer: advances the PC, resolves branches,
// stalls for a fixed flush window after a taken branch, and halts on request.
module cond_branch_seq #(
  parameter int    UUID         = 0,
  parameter string NAME         = "",
  parameter int    PC_STEP      = 4,
  parameter int    FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       is_branch,
  input  logic [7:0] cond,
  input  logic [7:0] value,
  input  logic [7:0] target,
  input  logic       halt_req,
  output logic [7:0] pc,
  output logic       taken,
  output logic       flush,
  output logic       halted
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic [7:0] STEP   = 8'(PC_STEP);
  localparam logic [3:0] FLUSHN = 4'(FLUSH_CYCLES);

  state_e     r_state, w_state_nxt;
  logic [7:0] r_pc, w_pc_nxt;
  logic       r_taken, w_taken_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_halt_pend, w_halt_pend_nxt;

  logic w_cond_true;
  logic w_accept;
  logic w_halt;
  logic w_zero;
  logic w_neg;

  // Identification parameters and the upper condition bits carry no function.
  logic w_unused;
  assign w_unused = (^cond[7:3]) ^ (UUID != 0) ^ (NAME == "");

  assign w_zero = (value == 8'd0);
  assign w_neg  = value[7];

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_cond_true = 1'b0;
    unique case (cond[2:0])
      3'd0: w_cond_true = 1'b0;
      3'd1: w_cond_true = w_zero;
      3'd2: w_cond_true = w_neg;
      3'd3: w_cond_true = w_zero | w_neg;
      3'd4: w_cond_true = 1'b1;
      3'd5: w_cond_true = ~w_zero;
      3'd6: w_cond_true = ~w_neg;
      3'd7: w_cond_true = ~w_zero & ~w_neg;
      default: w_cond_true = 1'b0;
    endcase
  end

  assign in_ready = (r_state == ST_RUN);
  assign w_accept = in_valid & in_ready;
  // A request arriving this cycle counts as pending immediately.
  assign w_halt   = r_halt_pend | halt_req;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_taken_nxt     = 1'b0;
    w_cnt_nxt       = r_cnt;
    w_halt_pend_nxt = r_halt_pend;
    unique case (r_state)
      ST_RUN: begin
        w_halt_pend_nxt = w_halt;
        if (w_accept) begin
          if (is_branch && w_cond_true) begin
            w_pc_nxt    = target;
            w_taken_nxt = 1'b1;
            w_cnt_nxt   = FLUSHN;
            w_state_nxt = ST_FLUSH;
          end else begin
            w_pc_nxt = r_pc + STEP;
            if (w_halt) w_state_nxt = ST_HALT;
          end
        end else if (w_halt) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_FLUSH: begin
        w_halt_pend_nxt = w_halt;
        if (r_cnt <= 4'd1) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = w_halt ? ST_HALT : ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_pc        <= 8'd0;
      r_taken     <= 1'b0;
      r_cnt       <= 4'd0;
      r_halt_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_taken     <= w_taken_nxt;
      r_cnt       <= w_cnt_nxt;
      r_halt_pend <= w_halt_pend_nxt;
    end
  end

  assign pc     = r_pc;
  assign taken  = r_taken;
  assign flush  = (r_state == ST_FLUSH);
  assign halted = (r_state == ST_HALT);

endmodule

// File: tb/tb_cond_branch_seq.sv
// Directed bench for cond_branch_seq: sequencing, condition table, flush window,
// pc wrap, halt handling and asynchronous reset.
module tb_cond_branch_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       is_branch;
  logic [7:0] cond;
  logic [7:0] value;
  logic [7:0] target;
  logic       halt_req;
  logic [7:0] pc;
  logic       taken;
  logic       flush;
  logic       halted;

  int n_vec = 0;
  int n_err = 0;

  cond_branch_seq #(
    .UUID(0), .NAME("dut"), .PC_STEP(4), .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .is_branch(is_branch), .cond(cond), .value(value), .target(target),
    .halt_req(halt_req), .pc(pc), .taken(taken), .flush(flush), .halted(halted)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; is_branch = 1'b0; cond = 8'd0;
    value = 8'd0; target = 8'd0; halt_req = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #3;
    n_vec++;
    if ({pc, in_ready, taken, flush, halted} !== {8'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: pc=%0d rdy=%b tk=%b fl=%b hl=%b, want pc=0 rdy=1 tk=0 fl=0 hl=0",
               pc, in_ready, taken, flush, halted);
    end
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_sequential();
    logic [7:0] exp_pc;
    do_reset();
    exp_pc = 8'd0;
    in_valid = 1'b1; is_branch = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      exp_pc = exp_pc + 8'd4;
      n_vec++;
      if (pc !== exp_pc || taken !== 1'b0) begin
        n_err++;
        $display("FAIL seq_step%0d: pc=%0d taken=%b, want pc=%0d taken=0", i, pc, taken, exp_pc);
      end
    end
    idle();
  endtask

  task automatic test_cond_sweep();
    logic [7:0] vals  [3];
    logic [7:0] masks [3];
    logic [7:0] m;
    logic       exp_tk;
    vals[0] = 8'h00; masks[0] = 8'h5A;
    vals[1] = 8'h80; masks[1] = 8'h3C;
    vals[2] = 8'h01; masks[2] = 8'hF0;
    for (int v = 0; v < 3; v++) begin
      for (int c = 0; c < 8; c++) begin
        do_reset();
        m = masks[v];
        exp_tk = m[c];
        in_valid = 1'b1; is_branch = 1'b1; cond = 8'(c);
        value = vals[v]; target = 8'h40;
        cycle();
        idle();
        n_vec++;
        if (taken !== exp_tk || pc !== (exp_tk ? 8'h40 : 8'h04)) begin
          n_err++;
          $display("FAIL cond_v%02h_c%0d: taken=%b pc=%02h, want taken=%b pc=%02h",
                   vals[v], c, taken, pc, exp_tk, exp_tk ? 8'h40 : 8'h04);
        end
      end
    end
  endtask

  task automatic test_taken_flush();
    do_reset();
    in_valid = 1'b1; is_branch = 1'b0;
    cycle(); cycle();
    n_vec++;
    if (pc !== 8'd8) begin
      n_err++; $display("FAIL flush_setup: pc=%0d want 8", pc);
    end
    is_branch = 1'b1; cond = 8'd4; target = 8'h20;
    cycle();
    is_branch = 1'b0; target = 8'h77;
    n_vec++;
    if ({pc, taken, flush, in_ready} !== {8'h20, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL flush_c1: pc=%02h tk=%b fl=%b rdy=%b, want pc=20 tk=1 fl=1 rdy=0",
               pc, taken, flush, in_ready);
    end
    cycle();
    n_vec++;
    if ({pc, taken, flush, in_ready} !== {8'h20, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL flush_c2: pc=%02h tk=%b fl=%b rdy=%b, want pc=20 tk=0 fl=1 rdy=0",
               pc, taken, flush, in_ready);
    end
    cycle();
    n_vec++;
    if ({pc, taken, flush, in_ready} !== {8'h20, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL flush_done: pc=%02h tk=%b fl=%b rdy=%b, want pc=20 tk=0 fl=0 rdy=1",
               pc, taken, flush, in_ready);
    end
    cycle();
    n_vec++;
    if (pc !== 8'h24 || taken !== 1'b0) begin
      n_err++; $display("FAIL flush_next: pc=%02h taken=%b, want pc=24 taken=0", pc, taken);
    end
    idle();
  endtask

  task automatic test_wrap();
    do_reset();
    in_valid = 1'b1; is_branch = 1'b1; cond = 8'd4; target = 8'hFC;
    cycle();
    idle();
    cycle(); cycle();
    in_valid = 1'b1;
    cycle();
    idle();
    n_vec++;
    if ({pc, taken, flush, in_ready} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL wrap: pc=%02h tk=%b fl=%b rdy=%b, want pc=00 tk=0 fl=0 rdy=1",
               pc, taken, flush, in_ready);
    end
  endtask

  task automatic test_halt();
    // Halt requested in RUN with nothing accepted.
    do_reset();
    halt_req = 1'b1;
    cycle();
    halt_req = 1'b0;
    n_vec++;
    if ({pc, halted, in_ready} !== {8'h00, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL halt_idle: pc=%02h hl=%b rdy=%b, want pc=00 hl=1 rdy=0", pc, halted, in_ready);
    end
    // Halt requested alongside an accepted sequential instruction.
    do_reset();
    halt_req = 1'b1; in_valid = 1'b1;
    cycle();
    idle(); in_valid = 1'b1;
    cycle();
    idle();
    n_vec++;
    if ({pc, halted, in_ready} !== {8'h04, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL halt_accept: pc=%02h hl=%b rdy=%b, want pc=04 hl=1 rdy=0", pc, halted, in_ready);
    end
    // Halt pulsed in the first flush cycle.
    do_reset();
    in_valid = 1'b1; is_branch = 1'b1; cond = 8'd4; target = 8'h30;
    cycle();
    is_branch = 1'b0; halt_req = 1'b1;
    cycle();
    halt_req = 1'b0;
    n_vec++;
    if ({flush, halted} !== 2'b10) begin
      n_err++; $display("FAIL halt_flush_mid: fl=%b hl=%b, want fl=1 hl=0", flush, halted);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_vec++;
      if ({pc, flush, halted, in_ready, taken} !== {8'h30, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL halt_flush_hold%0d: pc=%02h fl=%b hl=%b rdy=%b tk=%b, want pc=30 fl=0 hl=1 rdy=0 tk=0",
                 i, pc, flush, halted, in_ready, taken);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    in_valid = 1'b1; is_branch = 1'b1; cond = 8'd4; target = 8'h50;
    cycle();
    idle();
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({pc, flush, taken, halted} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rst_flush_async: pc=%02h fl=%b tk=%b hl=%b, want all 0", pc, flush, taken, halted);
    end
    rst = 1'b1;
    cycle();
    n_vec++;
    if ({pc, in_ready, flush, taken} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rst_flush_after: pc=%02h rdy=%b fl=%b tk=%b, want pc=00 rdy=1 fl=0 tk=0",
               pc, in_ready, flush, taken);
    end
    // Reset out of HALT clears the sticky halt.
    halt_req = 1'b1;
    cycle();
    idle();
    do_reset();
    in_valid = 1'b1;
    cycle();
    idle();
    n_vec++;
    if ({pc, halted, in_ready} !== {8'h04, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL rst_halt: pc=%02h hl=%b rdy=%b, want pc=04 hl=0 rdy=1", pc, halted, in_ready);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1;
    test_reset();
    test_sequential();
    test_cond_sweep();
    test_taken_flush();
    test_wrap();
    test_halt();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cond_branch_seq.md
COND_BRANCH_SEQ -- requirements
Module: cond_branch_seq

Interface
REQ-001 SHALL have parameter UUID, default 0, instance identifier, carried but functionally unused.
REQ-002 SHALL have parameter NAME, default "", instance label, functionally unused.
REQ-003 SHALL have parameter PC_STEP, default 4, byte increment per sequential instruction (1..255).
REQ-004 SHALL have parameter FLUSH_CYCLES, default 2, stall cycles after a taken branch (1..15).
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-007 SHALL have port in_valid  input  1  decoded instruction present.
REQ-008 SHALL have port in_ready  output  1  sequencer can accept an instruction this cycle.
REQ-009 SHALL have port is_branch  input  1  instruction is a conditional jump; 0 = sequential op.
REQ-010 SHALL have port cond  input  8  bits[2:0] condition code, bits[7:3] ignored.
REQ-011 SHALL have port value  input  8  two's-complement operand tested by the condition.
REQ-012 SHALL have port target  input  8  jump destination address.
REQ-013 SHALL have port halt_req  input  1  request to stop sequencing.
REQ-014 SHALL have port pc  output  8  current program counter (registered).
REQ-015 SHALL have port taken  output  1  one-cycle pulse, branch taken.
REQ-016 SHALL have port flush  output  1  high while in FLUSH state.
REQ-017 SHALL have port halted  output  1  high while in HALT state.

Function
REQ-018 SHALL evaluate cond[2:0] on value: 0 never; 1 value==0; 2 value[7]==1; 3 value==0 or value[7]; 4 always; 5 value!=0; 6 value[7]==0; 7 value!=0 and value[7]==0.
REQ-019 SHALL implement states RUN, FLUSH, HALT; in_ready=1 only in RUN; flush=1 only in FLUSH; halted=1 only in HALT.
REQ-020 SHALL accept an instruction on a cycle with in_valid=1 and in_ready=1; no state change in RUN when in_valid=0.
REQ-021 SHALL, on accepting a non-branch or an untaken branch, set pc <= (pc + PC_STEP) mod 256 at the next edge; state stays RUN.
REQ-022 SHALL, on accepting a taken branch, set pc <= target, assert taken for exactly the following cycle, load flush counter with FLUSH_CYCLES, enter FLUSH.
REQ-023 SHALL in FLUSH decrement the counter each cycle and return to RUN when it reaches 0, giving exactly FLUSH_CYCLES cycles with in_ready=0; pc held.
REQ-024 SHALL ignore in_valid, is_branch, cond, value, target while in FLUSH or HALT.
REQ-025 SHALL latch halt_req=1 seen in RUN or FLUSH into a sticky pending flag.
REQ-026 SHALL, with halt pending in RUN, complete any instruction accepted that same cycle (pc updated, taken/flush as normal) and then enter HALT; with no acceptance, enter HALT at the next edge.
REQ-027 SHALL, with halt pending in FLUSH, finish the full flush then enter HALT instead of RUN.
REQ-028 SHALL remain in HALT with pc frozen and in_ready=0 until reset; halt_req deassertion has no effect.
REQ-029 SHALL never assert taken on a cycle when flush was 0 in the previous cycle except as the pulse of REQ-022.
REQ-030 SHALL wrap pc from 252 + 4 to 0 with no flag and no stall.

Reset
REQ-031 SHALL, while rst=0, asynchronously force pc=0, state=RUN, taken=0, flush=0, halted=0, flush counter=0, halt pending=0; in_ready=1 after release.
REQ-032 SHALL abort a flush or halt in progress on reset assertion, with no residual pulse after release.

Verification
REQ-033 Sequential: reset, 3 accepted non-branch instructions -> pc 0,4,8,12 on successive edges, taken never high.
REQ-034 Condition sweep: is_branch=1, target=0x40, value in {0x00,0x80,0x01}, cond 0..7 each from pc=0 -> taken exactly per REQ-018 table (value 0x00: codes 1,3,4,6 taken; 0x80: 2,3,4,5; 0x01: 4,5,6,7).
REQ-035 Taken branch cond=4, target=0x20 at pc=8 -> pc=0x20, taken pulse 1 cycle, in_ready=0 for 2 cycles, next accept advances pc to 0x24.
REQ-036 Wrap: pc=252, non-branch accept -> pc=0.
REQ-037 Halt during flush: halt_req pulsed 1 cycle in first FLUSH cycle -> flush completes (2 cycles), halted=1, pc=target thereafter despite in_valid=1.
REQ-038 Reset mid-flush: rst=0 asynchronously in FLUSH -> pc=0, flush=0 immediately, in_ready=1 first cycle after release.
